// File: rtl/gumnut_alu_pkg.sv
// ============================================================================
// gumnut_alu_pkg : shared types, opcode prefixes and field positions
// Rev 1.0
// ============================================================================
`default_nettype none

package gumnut_alu_pkg;

  localparam int INSTR_W = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FMT_IMM = 2'd0,
    FMT_REG = 2'd1,
    FMT_SHF = 2'd2,
    FMT_ILL = 2'd3
  } fmt_t;

  localparam logic       OP_IMM = 1'b0;
  localparam logic [3:0] OP_REG = 4'b1110;
  localparam logic [2:0] OP_SHF = 3'b110;

  localparam int IMM_FN_LSB  = 14;
  localparam int IMM_RD_LSB  = 11;
  localparam int IMM_RS_LSB  = 8;
  localparam int REG_FN_LSB  = 11;
  localparam int REG_RD_LSB  = 8;
  localparam int REG_RS_LSB  = 5;
  localparam int REG_R2_LSB  = 2;
  localparam int SHF_RD_LSB  = 12;
  localparam int SHF_RS_LSB  = 9;
  localparam int SHF_CNT_LSB = 5;
  localparam int SHF_FN_LSB  = 0;

  typedef struct packed {
    logic       shift;
    logic       lgc;
    logic [1:0] fn;
  } alu_sel_t;

  function automatic fmt_t classify(input logic [INSTR_W-1:0] instr);
    if (instr[17] == OP_IMM)          return FMT_IMM;
    else if (instr[17:14] == OP_REG)  return FMT_REG;
    else if (instr[17:15] == OP_SHF)  return FMT_SHF;
    else                              return FMT_ILL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gumnut_regfile.sv
// ============================================================================
// gumnut_regfile : 8x8 register file, r0 hard zero, 1 write / 3 read ports
// Rev 1.0
// ============================================================================
`default_nettype none

module gumnut_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] rs_addr_i,
  output logic [DW-1:0] rs_data_o,
  input  logic [AW-1:0] r2_addr_i,
  output logic [DW-1:0] r2_data_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rs_data_o  = (rs_addr_i  == '0) ? '0 : mem_q[rs_addr_i];
  assign r2_data_o  = (r2_addr_i  == '0) ? '0 : mem_q[r2_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/gumnut_alu_ctrl.sv
// ============================================================================
// gumnut_alu_ctrl : IDLE/DECODE/EXEC/WB sequencer around the external ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module gumnut_alu_ctrl
  import gumnut_alu_pkg::*;
#(
  parameter int IW   = 18,
  parameter int DW   = 8,
  parameter int NREG = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_valid_i,
  input  logic [IW-1:0] instr_i,
  output logic          instr_ready_o,
  output logic [DW-1:0] alu_rs_o,
  output logic [DW-1:0] alu_op2_o,
  output logic [2:0]    alu_count_o,
  output logic          alu_carry_o,
  output logic [3:0]    alu_sel_o,
  input  logic [DW-1:0] alu_res_i,
  input  logic          alu_zero_i,
  input  logic          alu_carry_i,
  output logic          done_o,
  output logic          illegal_o,
  output logic          z_flag_o,
  output logic          c_flag_o,
  input  logic [2:0]    dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  localparam int AW = $clog2(NREG);

  state_t        state_q;
  logic [IW-1:0] instr_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] res_q;
  logic          zero_q, cout_q;
  logic          z_q, c_q;
  logic          done_q, illegal_q;
  logic [DW-1:0] alu_rs_q, alu_op2_q;
  logic [2:0]    alu_count_q;
  logic          alu_carry_q;
  alu_sel_t      alu_sel_q;

  fmt_t          fmt_d;
  logic [AW-1:0] rd_d, rs_addr_d, r2_addr_d;
  logic [2:0]    count_d;
  alu_sel_t      sel_d;
  logic          use_imm_d;
  logic [DW-1:0] rs_data, r2_data;

  assign fmt_d = classify(instr_q);

  always_comb begin
    rd_d      = '0;
    rs_addr_d = '0;
    r2_addr_d = '0;
    count_d   = '0;
    sel_d     = '0;
    use_imm_d = 1'b0;
    case (fmt_d)
      FMT_IMM: begin
        rd_d      = instr_q[IMM_RD_LSB +: 3];
        rs_addr_d = instr_q[IMM_RS_LSB +: 3];
        sel_d     = '{shift: 1'b0, lgc: instr_q[IMM_FN_LSB+2], fn: instr_q[IMM_FN_LSB +: 2]};
        use_imm_d = 1'b1;
      end
      FMT_REG: begin
        rd_d      = instr_q[REG_RD_LSB +: 3];
        rs_addr_d = instr_q[REG_RS_LSB +: 3];
        r2_addr_d = instr_q[REG_R2_LSB +: 3];
        sel_d     = '{shift: 1'b0, lgc: instr_q[REG_FN_LSB+2], fn: instr_q[REG_FN_LSB +: 2]};
      end
      FMT_SHF: begin
        rd_d      = instr_q[SHF_RD_LSB +: 3];
        rs_addr_d = instr_q[SHF_RS_LSB +: 3];
        count_d   = instr_q[SHF_CNT_LSB +: 3];
        sel_d     = '{shift: 1'b1, lgc: 1'b0, fn: instr_q[SHF_FN_LSB +: 2]};
      end
      default: ;
    endcase
  end

  gumnut_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .we_i       (state_q == WB),
    .waddr_i    (rd_q),
    .wdata_i    (res_q),
    .rs_addr_i  (rs_addr_d),
    .rs_data_o  (rs_data),
    .r2_addr_i  (r2_addr_d),
    .r2_data_o  (r2_data),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  // illegal_o is decided at capture so its pulse lines up with the DECODE cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      alu_rs_q    <= '0;
      alu_op2_q   <= '0;
      alu_count_q <= '0;
      alu_carry_q <= 1'b0;
      alu_sel_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            instr_q   <= instr_i;
            illegal_q <= (classify(instr_i) == FMT_ILL);
            state_q   <= DECODE;
          end
        end
        DECODE: begin
          if (illegal_q) begin
            state_q <= IDLE;
          end else begin
            alu_rs_q    <= rs_data;
            alu_op2_q   <= use_imm_d ? instr_q[7:0] : r2_data;
            alu_count_q <= count_d;
            alu_sel_q   <= sel_d;
            alu_carry_q <= c_q;
            rd_q        <= rd_d;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= alu_res_i;
          zero_q  <= alu_zero_i;
          cout_q  <= alu_carry_i;
          done_q  <= 1'b1;
          state_q <= WB;
        end
        WB: begin
          z_q     <= zero_q;
          c_q     <= cout_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready_o = (state_q == IDLE);
  assign alu_rs_o      = alu_rs_q;
  assign alu_op2_o     = alu_op2_q;
  assign alu_count_o   = alu_count_q;
  assign alu_carry_o   = alu_carry_q;
  assign alu_sel_o     = alu_sel_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
  assign z_flag_o      = z_q;
  assign c_flag_o      = c_q;

endmodule

`default_nettype wire

// File: tb/tb_gumnut_alu_ctrl.sv
// ============================================================================
// tb_gumnut_alu_ctrl : directed bench with a behavioural Gumnut ALU attached
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gumnut_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic [17:0] instr_i;
  logic        instr_ready_o;
  logic [7:0]  alu_rs_o, alu_op2_o;
  logic [2:0]  alu_count_o;
  logic        alu_carry_o;
  logic [3:0]  alu_sel_o;
  logic [7:0]  alu_res_i;
  logic        alu_zero_i, alu_carry_i;
  logic        done_o, illegal_o, z_flag_o, c_flag_o;
  logic [2:0]  dbg_addr_i;
  logic [7:0]  dbg_data_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [3:0] ex_sel;
  logic [2:0] ex_cnt;
  logic       ex_cy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gumnut_alu_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .alu_rs_o      (alu_rs_o),
    .alu_op2_o     (alu_op2_o),
    .alu_count_o   (alu_count_o),
    .alu_carry_o   (alu_carry_o),
    .alu_sel_o     (alu_sel_o),
    .alu_res_i     (alu_res_i),
    .alu_zero_i    (alu_zero_i),
    .alu_carry_i   (alu_carry_i),
    .done_o        (done_o),
    .illegal_o     (illegal_o),
    .z_flag_o      (z_flag_o),
    .c_flag_o      (c_flag_o),
    .dbg_addr_i    (dbg_addr_i),
    .dbg_data_o    (dbg_data_o)
  );

  // Behavioural stand-in for the combinational Gumnut ALU
  logic [8:0] s9, t9;
  always_comb begin
    s9          = '0;
    t9          = '0;
    alu_res_i   = '0;
    alu_carry_i = 1'b0;
    if (alu_sel_o[3]) begin
      case (alu_sel_o[1:0])
        2'd0: begin t9 = {1'b0, alu_rs_o} << alu_count_o; alu_res_i = t9[7:0]; alu_carry_i = t9[8]; end
        2'd1: begin t9 = {alu_rs_o, 1'b0} >> alu_count_o; alu_res_i = t9[8:1]; alu_carry_i = t9[0]; end
        2'd2: alu_res_i = (alu_rs_o << alu_count_o) | (alu_rs_o >> (4'd8 - {1'b0, alu_count_o}));
        default: alu_res_i = (alu_rs_o >> alu_count_o) | (alu_rs_o << (4'd8 - {1'b0, alu_count_o}));
      endcase
    end else if (alu_sel_o[2]) begin
      case (alu_sel_o[1:0])
        2'd0: alu_res_i = alu_rs_o & alu_op2_o;
        2'd1: alu_res_i = alu_rs_o | alu_op2_o;
        2'd2: alu_res_i = alu_rs_o ^ alu_op2_o;
        default: alu_res_i = alu_rs_o & ~alu_op2_o;
      endcase
    end else begin
      case (alu_sel_o[1:0])
        2'd0: s9 = {1'b0, alu_rs_o} + {1'b0, alu_op2_o};
        2'd1: s9 = {1'b0, alu_rs_o} + {1'b0, alu_op2_o} + {8'd0, alu_carry_o};
        2'd2: s9 = {1'b0, alu_rs_o} - {1'b0, alu_op2_o};
        default: s9 = {1'b0, alu_rs_o} - {1'b0, alu_op2_o} - {8'd0, alu_carry_o};
      endcase
      alu_res_i   = s9[7:0];
      alu_carry_i = s9[8];
    end
    alu_zero_i = (alu_res_i == 8'd0);
  end

  function automatic logic [17:0] enc_imm(input logic [2:0] fn, rd, rs, input logic [7:0] imm);
    return {1'b0, fn, rd, rs, imm};
  endfunction

  function automatic logic [17:0] enc_reg(input logic [2:0] fn, rd, rs, r2);
    return {4'b1110, fn, rd, rs, r2, 2'b00};
  endfunction

  function automatic logic [17:0] enc_shf(input logic [2:0] rd, rs, cnt, input logic [1:0] fn);
    return {3'b110, rd, rs, 1'b0, cnt, 3'b000, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr_i = a;
    #1;
    check(tag, {24'd0, dbg_data_o}, {24'd0, exp});
  endtask

  // Issue one word from IDLE; returns the negedge index (after accept) where done_o was seen.
  task automatic run_instr(input logic [17:0] w, output int lat);
    @(negedge clk);
    instr_valid_i = 1'b1;
    instr_i       = w;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) begin
        ex_sel = alu_sel_o;
        ex_cnt = alu_count_o;
        ex_cy  = alu_carry_o;
      end
      if (done_o) begin
        lat = k;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int idx;
    int acc [3];
    logic [17:0] tw [3];
    bit seen;

    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; dbg_addr_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, instr_ready_o}, 32'd1);
    check("rst_alu", {alu_rs_o, alu_op2_o, 8'd0, 1'b0, alu_count_o, alu_sel_o}, 32'd0);
    check("rst_carry", {31'd0, alu_carry_o}, 32'd0);
    check("rst_pulses", {30'd0, done_o, illegal_o}, 32'd0);
    check("rst_flags", {30'd0, z_flag_o, c_flag_o}, 32'd0);
    for (int r = 1; r < 8; r++) check_reg("rst_reg", 3'(r), 8'h00);

    // r1 = r0 + 0x05
    run_instr(enc_imm(3'd0, 3'd1, 3'd0, 8'h05), lat);
    check("add_imm_lat", lat, 32'd3);
    check_reg("add_imm_r1", 3'd1, 8'h05);
    check("add_imm_flags", {30'd0, z_flag_o, c_flag_o}, 32'd0);

    // r3 = r1 + r2 with 0xFF + 0x01
    run_instr(enc_imm(3'd0, 3'd1, 3'd0, 8'hFF), lat);
    run_instr(enc_imm(3'd0, 3'd2, 3'd0, 8'h01), lat);
    run_instr(enc_reg(3'd0, 3'd3, 3'd1, 3'd2), lat);
    check_reg("add_reg_r3", 3'd3, 8'h00);
    check("add_reg_flags", {30'd0, z_flag_o, c_flag_o}, 32'd3);

    // r4 = r0 + 0 + C
    run_instr(enc_imm(3'd1, 3'd4, 3'd0, 8'h00), lat);
    check("addc_exec_cin", {31'd0, ex_cy}, 32'd1);
    check_reg("addc_r4", 3'd4, 8'h01);
    check("addc_flags", {30'd0, z_flag_o, c_flag_o}, 32'd0);

    // rd = r0: result discarded, flags still written
    run_instr(enc_imm(3'd0, 3'd0, 3'd0, 8'h00), lat);
    check("rd0_done_lat", lat, 32'd3);
    check_reg("rd0_r0", 3'd0, 8'h00);
    check("rd0_zflag", {31'd0, z_flag_o}, 32'd1);

    // rol r1=0x81 by 1 into r2
    run_instr(enc_imm(3'd0, 3'd1, 3'd0, 8'h81), lat);
    run_instr(enc_shf(3'd2, 3'd1, 3'd1, 2'd2), lat);
    check("rol_sel", {28'd0, ex_sel}, 32'hA);
    check("rol_cnt", {29'd0, ex_cnt}, 32'd1);
    check_reg("rol_r2", 3'd2, 8'h03);
    check("rol_flags", {30'd0, z_flag_o, c_flag_o}, 32'd0);

    // Illegal encoding
    @(negedge clk);
    instr_valid_i = 1'b1; instr_i = 18'h3F000;
    @(posedge clk);
    #1 instr_valid_i = 1'b0;
    @(negedge clk);
    check("ill_pulse", {31'd0, illegal_o}, 32'd1);
    check("ill_busy", {30'd0, instr_ready_o, done_o}, 32'd0);
    @(negedge clk);
    check("ill_ready", {30'd0, instr_ready_o, illegal_o}, 32'd2);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("ill_no_done", {31'd0, seen}, 32'd0);
    check_reg("ill_r1", 3'd1, 8'h81);
    check_reg("ill_r2", 3'd2, 8'h03);
    check("ill_flags", {30'd0, z_flag_o, c_flag_o}, 32'd0);

    // Back-to-back with valid held high
    tw[0] = enc_imm(3'd0, 3'd5, 3'd0, 8'h10);
    tw[1] = enc_reg(3'd0, 3'd6, 3'd5, 3'd5);
    tw[2] = enc_imm(3'd0, 3'd7, 3'd6, 8'hF0);
    idx = 0;
    instr_i = tw[0];
    instr_valid_i = 1'b1;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      @(negedge clk);
      if (instr_ready_o) begin
        acc[idx] = cyc;
        @(posedge clk);
        #1;
        idx++;
        if (idx < 3) instr_i = tw[idx];
        else instr_valid_i = 1'b0;
      end
    end
    instr_valid_i = 1'b0;
    check("tput_accepts", idx, 32'd3);
    if (idx == 3) begin
      check("tput_gap01", acc[1] - acc[0], 32'd4);
      check("tput_gap12", acc[2] - acc[1], 32'd4);
    end
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("tput_last_done", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check_reg("tput_r6", 3'd6, 8'h20);
    check_reg("tput_r7", 3'd7, 8'h10);
    check("tput_flags", {30'd0, z_flag_o, c_flag_o}, 32'd1);

    // Reset asserted during EXEC
    @(negedge clk);
    instr_valid_i = 1'b1; instr_i = enc_imm(3'd0, 3'd1, 3'd0, 8'h55);
    @(posedge clk);
    #1 instr_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, instr_ready_o}, 32'd1);
    check("mid_rst_flags", {30'd0, z_flag_o, c_flag_o}, 32'd0);
    seen = done_o;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("mid_rst_no_done", {31'd0, seen}, 32'd0);
    for (int r = 1; r < 8; r++) check_reg("mid_rst_reg", 3'(r), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
